mode_decision_luma16x16: RTL

MODE_DECISION_LUMA16X16 -- requirements
Module: mode_decision_luma16x16

---
 rtl/mode_decision_luma16x16.sv | 105 ++++++++++
 1 files changed

// File: rtl/mode_decision_luma16x16.sv
// mode_decision_luma16x16: 16x16 luma intra mode decision by minimum SAD over V/H/DC residuals
// Ports:
//   clk, reset (async, active-low)  clock and reset
//   start                           begin one macroblock evaluation (sampled in IDLE only)
//   top_avail, left_avail           neighbour availability, latched at start; gate V and H
//   vres, hres, dcres               256 signed 8-bit residuals each, element i at [8*i+7:8*i], i = 16*row+col
//   busy                            high whenever not IDLE
//   done                            one-cycle pulse with best_mode/best_cost valid
//   best_mode, best_cost            0 = V, 1 = H, 2 = DC and its SAD
//   vcost, hcost, dccost            per-mode SAD of the last completed run
module mode_decision_luma16x16 #(
  parameter int COST_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              top_avail,
  input  logic              left_avail,
  input  logic [2047:0]     vres,
  input  logic [2047:0]     hres,
  input  logic [2047:0]     dcres,
  output logic              busy,
  output logic              done,
  output logic [1:0]        best_mode,
  output logic [COST_W-1:0] best_cost,
  output logic [COST_W-1:0] vcost,
  output logic [COST_W-1:0] hcost,
  output logic [COST_W-1:0] dccost
);
  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;
  state_t state, state_nxt;
  logic [3:0] row;
  logic [COST_W-1:0] vacc, hacc, dacc;
  logic top_q, left_q;
  logic [11:0] vrow, hrow, drow;
  logic h_ok, v_ok;
  logic [1:0] mode_hd, sel_mode;
  logic [COST_W-1:0] cost_hd, sel_cost;
  // 8-bit unsigned magnitude: -128 wraps to 8'h80, which reads as 128
  function automatic logic [7:0] mag(input logic [7:0] x);
    return x[7] ? ~x + 8'd1 : x;
  endfunction
  // Sum of 16 magnitudes of one row; {r, c, 3'b000} is the bit offset 128*r + 8*c
  function automatic logic [11:0] row_sum(input logic [2047:0] res, input logic [3:0] r);
    logic [11:0] s;
    s = '0;
    for (int c = 0; c < 16; c++) s = s + 12'(mag(res[{r, c[3:0], 3'b000} +: 8]));
    return s;
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (start ? ACCUM : IDLE) :
                state == ACCUM ? (row == 4'd15 ? DECIDE : ACCUM) : IDLE;
  // Candidate chain DC -> H -> V with <= so ties fall to the lower mode number
  always_comb begin
    busy     = state != IDLE;
    vrow     = row_sum(vres, row);
    hrow     = row_sum(hres, row);
    drow     = row_sum(dcres, row);
    h_ok     = left_q && hacc <= dacc;
    mode_hd  = h_ok ? 2'd1 : 2'd2;
    cost_hd  = h_ok ? hacc : dacc;
    v_ok     = top_q && vacc <= cost_hd;
    sel_mode = v_ok ? 2'd0 : mode_hd;
    sel_cost = v_ok ? vacc : cost_hd;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row       <= '0;
      vacc      <= '0;
      hacc      <= '0;
      dacc      <= '0;
      top_q     <= 1'b0;
      left_q    <= 1'b0;
      done      <= 1'b0;
      best_mode <= '0;
      best_cost <= '0;
      vcost     <= '0;
      hcost     <= '0;
      dccost    <= '0;
    end else begin
      done <= state == DECIDE;
      if (state == IDLE && start) begin
        row    <= '0;
        vacc   <= '0;
        hacc   <= '0;
        dacc   <= '0;
        top_q  <= top_avail;
        left_q <= left_avail;
      end else if (state == ACCUM) begin
        row  <= row + 4'd1;
        vacc <= vacc + COST_W'(vrow);
        hacc <= hacc + COST_W'(hrow);
        dacc <= dacc + COST_W'(drow);
      end else if (state == DECIDE) begin
        vcost     <= vacc;
        hcost     <= hacc;
        dccost    <= dacc;
        best_mode <= sel_mode;
        best_cost <= sel_cost;
      end
    end
endmodule
